// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and helpers for the configurable UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE2} parity_t;
  typedef enum logic [1:0] {DB5, DB6, DB7, DB8} dbits_t;
  localparam int MIN_CPB_DEF = 4;
  function automatic logic [2:0] last_idx(input dbits_t db);
    return {1'b1, db};
  endfunction
  function automatic logic par_en(input parity_t pm);
    return pm == PAR_EVEN || pm == PAR_ODD;
  endfunction
endpackage

// File: rtl/uart_rx_sync_vote.sv
// uart_rx_sync_vote: two-flop line synchroniser plus 3-sample majority vote
// Ports: i_Clock/rst_i clock and async reset, i_Rx_Serial raw line,
//        o_Sync synchronised line, o_Vote majority of the last three synchronised samples
module uart_rx_sync_vote (
  input  logic i_Clock,
  input  logic rst_i,
  input  logic i_Rx_Serial,
  output logic o_Sync,
  output logic o_Vote
);
  logic       r_meta, r_sync;
  logic [1:0] r_hist;
  always_ff @(posedge i_Clock or posedge rst_i)
    if (rst_i) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 2'b11;
    end else begin
      r_meta <= i_Rx_Serial;
      r_sync <= r_meta;
      r_hist <= {r_hist[0], r_sync};
    end
  assign o_Sync = r_sync;
  assign o_Vote = (r_sync & r_hist[0]) | (r_sync & r_hist[1]) | (r_hist[0] & r_hist[1]);
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with runtime frame format, break detection and valid/ready output
// Ports: i_Clock/rst_i clock and async reset, i_Rx_Serial line, CLKS_PER_BIT divisor,
//        i_Data_Bits/i_Parity_Mode/i_Stop_Bits frame format, o_Rx_Valid/i_Rx_Ready handshake,
//        o_Rx_Byte word, o_Parity_Err/o_Frame_Err/o_Break per-word flags, o_Overrun sticky drop, o_Busy
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int MIN_CPB = MIN_CPB_DEF
) (
  input  logic             i_Clock,
  input  logic             rst_i,
  input  logic             i_Rx_Serial,
  input  logic [DIV_W-1:0] CLKS_PER_BIT,
  input  logic [1:0]       i_Data_Bits,
  input  logic [1:0]       i_Parity_Mode,
  input  logic             i_Stop_Bits,
  output logic             o_Rx_Valid,
  input  logic             i_Rx_Ready,
  output logic [7:0]       o_Rx_Byte,
  output logic             o_Parity_Err,
  output logic             o_Frame_Err,
  output logic             o_Break,
  output logic             o_Overrun,
  output logic             o_Busy
);
  state_t           r_state;
  logic [DIV_W-1:0] r_cnt, r_cpb;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  dbits_t           r_dbits;
  parity_t          r_pmode;
  logic             r_stop2, r_par, r_nz, r_perr, r_ferr, r_brk;
  logic             w_sync, w_vote, w_tick, w_half, w_hs, w_done, w_brk, w_ferr;
  logic [7:0]       w_word;
  uart_rx_sync_vote u_sv (
    .i_Clock    (i_Clock),
    .rst_i      (rst_i),
    .i_Rx_Serial(i_Rx_Serial),
    .o_Sync     (w_sync),
    .o_Vote     (w_vote)
  );
  assign w_tick = r_cnt == r_cpb - DIV_W'(1);
  assign w_half = r_cnt == ((r_cpb - DIV_W'(1)) >> 1);
  assign w_hs   = o_Rx_Valid & i_Rx_Ready;
  assign w_done = w_tick && ((r_state == STOP1 && !r_stop2) || r_state == STOP2);
  // break is decided on the first stop bit and carried through a second one
  assign w_brk  = r_state == STOP1 ? !r_nz && !w_vote : r_brk;
  assign w_ferr = r_ferr | !w_vote;
  // bits enter at the MSB, so shorter words sit high and are shifted down
  assign w_word = r_shift >> (2'd3 - r_dbits);
  assign o_Busy = r_state != IDLE;
  always_ff @(posedge i_Clock or posedge rst_i)
    if (rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_cpb        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_dbits      <= DB8;
      r_pmode      <= PAR_NONE;
      r_stop2      <= 1'b0;
      r_par        <= 1'b0;
      r_nz         <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_brk        <= 1'b0;
      o_Rx_Valid   <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      if (w_hs) begin
        o_Rx_Valid <= 1'b0;
        o_Overrun  <= 1'b0;
      end
      if (w_done) begin
        if (!o_Rx_Valid || w_hs) begin
          o_Rx_Valid   <= 1'b1;
          o_Rx_Byte    <= w_word;
          o_Parity_Err <= r_perr;
          o_Frame_Err  <= w_ferr;
          o_Break      <= w_brk;
        end else
          o_Overrun <= 1'b1;
      end
      r_cnt <= (r_state inside {IDLE, BRKWAIT} || w_tick || (r_state == START && w_half)) ? '0 : r_cnt + DIV_W'(1);
      case (r_state)
        IDLE:
          if (!w_sync) begin
            r_state <= START;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_nz    <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_brk   <= 1'b0;
            r_cpb   <= CLKS_PER_BIT < DIV_W'(MIN_CPB) ? DIV_W'(MIN_CPB) : CLKS_PER_BIT;
            r_dbits <= dbits_t'(i_Data_Bits);
            r_pmode <= parity_t'(i_Parity_Mode);
            r_stop2 <= i_Stop_Bits;
          end
        START:
          if (w_half) r_state <= w_vote ? IDLE : DATA;
        DATA:
          if (w_tick) begin
            r_shift <= {w_vote, r_shift[7:1]};
            r_par   <= r_par ^ w_vote;
            r_nz    <= r_nz | w_vote;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == last_idx(r_dbits)) r_state <= par_en(r_pmode) ? PARITY : STOP1;
          end
        PARITY:
          if (w_tick) begin
            r_perr  <= r_par ^ w_vote ^ (r_pmode == PAR_ODD);
            r_nz    <= r_nz | w_vote;
            r_state <= STOP1;
          end
        STOP1:
          if (w_tick) begin
            r_ferr  <= !w_vote;
            r_brk   <= w_brk;
            r_state <= r_stop2 ? STOP2 : w_brk ? BRKWAIT : IDLE;
          end
        STOP2:
          if (w_tick) r_state <= r_brk ? BRKWAIT : IDLE;
        BRKWAIT:
          if (w_sync) r_state <= IDLE;
        default:
          r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed scoreboard bench for uart_rx_cfg at 16 clocks per bit
module tb_uart_rx_cfg;
  typedef struct packed {logic [7:0] b; logic p, f, k;} exp_t;
  logic        clk = 1'b0;
  logic        rst, ser, ready, stop;
  logic [1:0]  db, pm;
  logic [15:0] cpb;
  logic        valid, perr, ferr, brk, ovr, busy;
  logic [7:0]  rbyte;
  exp_t        q[$];
  int          cc = 0, t_start = 0, t_valid = 0, vlen = 0, last_len = 0, n_words = 0;
  int          n_cmp = 0, n_bad = 0, w;
  logic        prev_v = 1'b0;
  uart_rx_cfg dut (
    .i_Clock      (clk),
    .rst_i        (rst),
    .i_Rx_Serial  (ser),
    .CLKS_PER_BIT (cpb),
    .i_Data_Bits  (db),
    .i_Parity_Mode(pm),
    .i_Stop_Bits  (stop),
    .o_Rx_Valid   (valid),
    .i_Rx_Ready   (ready),
    .o_Rx_Byte    (rbyte),
    .o_Parity_Err (perr),
    .o_Frame_Err  (ferr),
    .o_Break      (brk),
    .o_Overrun    (ovr),
    .o_Busy       (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bit(input logic b);
    ser = b;
    cyc(16);
  endtask
  task automatic send_frame(input logic [7:0] d, input int nd, input int pb, input logic s1, input int ns, input logic s2);
    t_start = cc;
    send_bit(1'b0);
    for (int i = 0; i < nd; i++) send_bit(d[i]);
    if (pb >= 0) send_bit(pb[0]);
    send_bit(s1);
    if (ns == 2) send_bit(s2);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 400 && q.size() != 0; i++) cyc(1);
    chk(tag, 32'(q.size()), 32'd0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (valid && !prev_v) t_valid = cc;
    if (valid) vlen++;
    else if (prev_v) begin
      last_len = vlen;
      vlen = 0;
    end
    prev_v = valid;
    if (valid && ready) begin
      n_words++;
      chk("word_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rx_byte", 32'(rbyte), 32'(e.b));
        chk("parity_err", 32'(perr), 32'(e.p));
        chk("frame_err", 32'(ferr), 32'(e.f));
        chk("break", 32'(brk), 32'(e.k));
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; ser = 1'b1; ready = 1'b1; cpb = 16'd16; db = 2'b11; pm = 2'b00; stop = 1'b0;
    cyc(3);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_byte", 32'(rbyte), 32'd0);
    chk("rst_flags", 32'({perr, ferr, brk, ovr}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc(5);
    // 8N1 0xA5
    q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
    send_frame(8'hA5, 8, -1, 1'b1, 1, 1'b1);
    send_bit(1'b1);
    drain("drain_8n1");
    chk("valid_latency", 32'(t_valid - t_start), 32'd155);
    chk("valid_width", 32'(last_len), 32'd1);
    // 7E1 0x35, good then bad parity; format changes mid-frame must be ignored
    db = 2'b10; pm = 2'b01;
    q.push_back('{8'h35, 1'b0, 1'b0, 1'b0});
    send_frame(8'h35, 7, 0, 1'b1, 1, 1'b1);
    send_bit(1'b1);
    q.push_back('{8'h35, 1'b1, 1'b0, 1'b0});
    fork
      begin
        cyc(40);
        db = 2'b11;
        pm = 2'b00;
      end
    join_none
    send_frame(8'h35, 7, 1, 1'b1, 1, 1'b1);
    send_bit(1'b1);
    drain("drain_7e1");
    // 8N2 0x3C with second stop low
    db = 2'b11; pm = 2'b00; stop = 1'b1;
    q.push_back('{8'h3C, 1'b0, 1'b1, 1'b0});
    send_frame(8'h3C, 8, -1, 1'b1, 2, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    drain("drain_8n2");
    // break: 12 bit times low
    stop = 1'b0;
    q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    ser = 1'b0;
    cyc(12 * 16);
    chk("brk_wait_busy", 32'(busy), 32'd1);
    ser = 1'b1;
    cyc(16 * 3);
    drain("drain_break");
    w = n_words;
    cyc(16 * 2);
    chk("brk_no_extra", 32'(n_words), 32'(w));
    chk("brk_idle", 32'(busy), 32'd0);
    // overrun: two frames held off by ready=0
    ready = 1'b0;
    q.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
    send_frame(8'h11, 8, -1, 1'b1, 1, 1'b1);
    send_bit(1'b1);
    chk("ovr_first_clear", 32'(ovr), 32'd0);
    send_frame(8'h22, 8, -1, 1'b1, 1, 1'b1);
    send_bit(1'b1);
    chk("ovr_valid", 32'(valid), 32'd1);
    chk("ovr_held_byte", 32'(rbyte), 32'h11);
    chk("ovr_flag", 32'(ovr), 32'd1);
    ready = 1'b1;
    cyc(1);
    chk("ovr_hs_valid", 32'(valid), 32'd0);
    chk("ovr_hs_flag", 32'(ovr), 32'd0);
    drain("drain_ovr");
    // glitch, then reset in the middle of DATA while a word is held
    ready = 1'b0;
    send_frame(8'h81, 8, -1, 1'b1, 1, 1'b1);
    send_bit(1'b1);
    chk("held_valid", 32'(valid), 32'd1);
    w = n_words;
    ser = 1'b0;
    cyc(5);
    ser = 1'b1;
    cyc(40);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_ovr", 32'(ovr), 32'd0);
    chk("glitch_held", 32'(rbyte), 32'h81);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    cyc(5);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_byte", 32'(rbyte), 32'd0);
    chk("arst_flags", 32'({perr, ferr, brk, ovr}), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    ser = 1'b1;
    cyc(3);
    rst = 1'b0;
    ready = 1'b1;
    cyc(20);
    chk("arst_no_word", 32'(n_words), 32'(w));
    q.push_back('{8'hC3, 1'b0, 1'b0, 1'b0});
    send_frame(8'hC3, 8, -1, 1'b1, 1, 1'b1);
    send_bit(1'b1);
    drain("drain_after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, giving the width of the bit-period divisor.
REQ-002 The block SHALL have parameter MIN_CPB, default 4, giving the minimum legal CLKS_PER_BIT; smaller values are unsupported.
REQ-003 The block SHALL have the following ports, clock and reset first:
- i_Clock  in  1  sole clock
- rst_i  in  1  reset, asynchronous, active-high
- i_Rx_Serial  in  1  asynchronous serial line, idle high
- CLKS_PER_BIT  in  DIV_W  i_Clock cycles per bit
- i_Data_Bits  in  2  data length: 00=5, 01=6, 10=7, 11=8
- i_Parity_Mode  in  2  parity: 00=none, 01=even, 10=odd, 11=none
- i_Stop_Bits  in  1  stop bits: 0=one, 1=two
- o_Rx_Valid  out  1  held word available
- i_Rx_Ready  in  1  consumer accepts the held word
- o_Rx_Byte  out  8  received data, LSB-first, unused upper bits zero
- o_Parity_Err  out  1  parity mismatch for the held word
- o_Frame_Err  out  1  a stop bit sampled low for the held word
- o_Break  out  1  break detected for the held word
- o_Overrun  out  1  sticky flag: a frame was dropped
- o_Busy  out  1  high in any state other than IDLE

Function
REQ-004 i_Rx_Serial SHALL pass through a two-flop synchroniser; both flops reset to 1.
REQ-005 Each bit value SHALL be the majority of the last three synchronised samples, ending at the sample point.
REQ-006 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP1, STOP2 and BRKWAIT.
REQ-007 IDLE SHALL move to START when the synchronised line is 0; the bit counter, bit index and shift register SHALL clear.
REQ-008 On leaving IDLE, i_Data_Bits, i_Parity_Mode, i_Stop_Bits and CLKS_PER_BIT SHALL be latched; changes during a frame SHALL have no effect on that frame.
REQ-009 START SHALL vote at count (CPB-1)/2: a 0 goes to DATA with count reset to 0; a 1 returns to IDLE with no output.
REQ-010 DATA, PARITY, STOP1 and STOP2 SHALL each sample when count reaches CPB-1, then reset count to 0.
REQ-011 DATA SHALL shift in N bits, LSB-first, and then go to PARITY if parity is enabled, else to STOP1.
REQ-012 In PARITY, o_Parity_Err SHALL be set for the frame when the XOR of the data bits and the parity bit is 1 in even mode, or 0 in odd mode; otherwise it SHALL be cleared.
REQ-013 STOP1 SHALL go to STOP2 when two stop bits are selected, else it SHALL complete the frame; STOP2 SHALL complete the frame.
REQ-014 o_Frame_Err SHALL be set when any stop sample of the frame is 0.
REQ-015 Break SHALL be flagged when all data bits, the parity bit (if enabled) and the first stop bit are 0; the word is then 0x00 with o_Frame_Err=1.
REQ-016 After frame completion, a break SHALL go to BRKWAIT, which returns to IDLE on a synchronised 1; every other frame SHALL go directly to IDLE.
REQ-017 On frame completion with o_Rx_Valid=0, the cycle after the final sample point SHALL load o_Rx_Byte, o_Parity_Err, o_Frame_Err and o_Break, and set o_Rx_Valid=1.
REQ-018 On frame completion with o_Rx_Valid=1 and no same-cycle handshake, the new frame SHALL be discarded, the held word and flags SHALL be retained, and o_Overrun SHALL be set.
REQ-019 Frame completion in the same cycle as a handshake SHALL load the new word with no overrun.
REQ-020 o_Rx_Valid SHALL clear on o_Rx_Valid and i_Rx_Ready both high; o_Overrun SHALL also clear on that handshake.
REQ-021 Output word and flags SHALL be stable while o_Rx_Valid=1 and no handshake has occurred.
REQ-022 The bit counter SHALL be DIV_W wide, and every comparison SHALL use the latched CPB.

Reset
REQ-023 Asserting rst_i SHALL immediately force IDLE, clear all counters and the shift register, and set o_Rx_Valid, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun and o_Busy to 0.
REQ-024 A partial frame interrupted by reset SHALL produce no output; reception SHALL resume on the first falling edge after rst_i deasserts.

Structure
REQ-025 Package uart_pkg SHALL hold the state encoding, the parity-mode and data-length encodings, and the MIN_CPB default.
REQ-026 One sub-module, uart_rx_sync_vote, SHALL contain the synchroniser and the 3-sample majority vote.

Verification (CPB=16 in all scenarios)
REQ-027 8N1, 0xA5, ready=1 -> o_Rx_Byte=0xA5 with all error flags 0; o_Rx_Valid pulses for one cycle, one cycle after the stop sample.
REQ-028 7E1, 0x35 with parity bit 0, then with parity bit 1 -> first word 0x35 with o_Parity_Err=0; second word 0x35 with o_Parity_Err=1.
REQ-029 8N2, 0x3C with second stop bit low -> o_Rx_Byte=0x3C with o_Frame_Err=1 and o_Break=0.
REQ-030 Line low for 12 bit times (8N1) -> one word 0x00 with o_Break=1 and o_Frame_Err=1; no further word until the line returns high and a new start bit arrives.
REQ-031 Frames 0x11 then 0x22 with ready=0, then ready=1 -> held word 0x11 with o_Overrun=1; after the handshake, o_Rx_Valid=0 and o_Overrun=0.
REQ-032 A 5-cycle low glitch, then rst_i asserted mid-frame during DATA -> no output word, all outputs 0, and the next full frame is received correctly.
